// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the UART TX arbiter, its byte producers and the serializer.
// master = arbiter side, slave = producers/serializer side.
interface uart_tx_arbiter_if #(
    parameter int SIZE  = 8,
    parameter int N_REQ = 4
);
    localparam int IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0]      REQ;
    logic [N_REQ-1:0]      LOCK;
    logic [N_REQ*SIZE-1:0] DATA;
    logic [N_REQ-1:0]      ACK;
    logic [SIZE-1:0]       TXDATA;
    logic                  TX_RQ;
    logic                  TX_BUSY;
    logic [IDX_W-1:0]      OWNER;
    logic                  ACTIVE;

    modport master (
        input  REQ, LOCK, DATA, TX_BUSY,
        output ACK, TXDATA, TX_RQ, OWNER, ACTIVE
    );

    modport slave (
        output REQ, LOCK, DATA, TX_BUSY,
        input  ACK, TXDATA, TX_RQ, OWNER, ACTIVE
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX serializer between N_REQ byte producers (round-robin, with owner lock).
// Define UART_TX_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index priority.
module uart_tx_arbiter #(
    parameter int SIZE  = 8,
    parameter int N_REQ = 4
) (
    input  logic               CLK,
    input  logic               R,
    uart_tx_arbiter_if.master  bus
);
    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, LAUNCH, SEND} state_t;

    state_t            state;
    logic [SIZE-1:0]   txdata_q;
    logic              tx_rq_q;
    logic [N_REQ-1:0]  ack_q;
    logic [IDX_W-1:0]  owner_q;
    logic              active_q;

    logic [IDX_W-1:0]  winner;
    logic [IDX_W-1:0]  grant_idx;
    logic              relock;
    logic              do_grant;

`ifdef UART_TX_ARB_FIXED_PRIO_EN
    always_comb begin
        winner = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (bus.REQ[IDX_W'(i)]) winner = IDX_W'(i);
        end
    end
`else
    logic [IDX_W-1:0] last_q;

    // Search begins just after the previous winner and wraps around.
    always_comb begin
        logic found;
        int   idx;
        winner = last_q;
        found  = 1'b0;
        idx    = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(last_q) + i) % N_REQ;
            if (!found && bus.REQ[IDX_W'(idx)]) begin
                winner = IDX_W'(idx);
                found  = 1'b1;
            end
        end
    end
`endif

    assign relock    = bus.LOCK[owner_q] & bus.REQ[owner_q];
    assign grant_idx = (state == SEND) ? owner_q : winner;
    assign do_grant  = !bus.TX_BUSY &&
                       (((state == IDLE) && (|bus.REQ)) || ((state == SEND) && relock));

    // A grant from IDLE and a lock regrant at the end of SEND take identical actions.
    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            state    <= IDLE;
            txdata_q <= '0;
            tx_rq_q  <= 1'b0;
            ack_q    <= '0;
            owner_q  <= '0;
            active_q <= 1'b0;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
            last_q   <= IDX_W'(N_REQ - 1);
`endif
        end else begin
            ack_q <= '0;
            if (do_grant) begin
                txdata_q <= bus.DATA[int'(grant_idx)*SIZE +: SIZE];
                ack_q    <= {{(N_REQ-1){1'b0}}, 1'b1} << grant_idx;
                tx_rq_q  <= 1'b1;
                owner_q  <= grant_idx;
                active_q <= 1'b1;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
                last_q   <= grant_idx;
`endif
                state    <= LAUNCH;
            end else begin
                case (state)
                    IDLE: ;
                    LAUNCH: begin
                        // Drop TX_RQ once the serializer has started, so it does not restart.
                        if (bus.TX_BUSY) begin
                            tx_rq_q <= 1'b0;
                            state   <= SEND;
                        end
                    end
                    SEND: begin
                        if (!bus.TX_BUSY) begin
                            active_q <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.ACK    = ack_q;
    assign bus.TXDATA = txdata_q;
    assign bus.TX_RQ  = tx_rq_q;
    assign bus.OWNER  = owner_q;
    assign bus.ACTIVE = active_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: serializer model plus a grant scoreboard.
// Expected grant order follows UART_TX_ARB_FIXED_PRIO_EN when it is defined.
module tb_uart_tx_arbiter;
    localparam int SIZE  = 8;
    localparam int N_REQ = 4;

    typedef struct {
        int         idx;
        logic [7:0] data;
    } exp_t;

    logic CLK = 1'b0;
    logic R   = 1'b1;
    logic force_busy = 1'b0;
    int   busy_cnt   = 0;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic [N_REQ-1:0] prev_ack = '0;
    logic saw_idle;
    logic [31:0] data_v;

    uart_tx_arbiter_if #(.SIZE(SIZE), .N_REQ(N_REQ)) arb_bus ();

    uart_tx_arbiter #(.SIZE(SIZE), .N_REQ(N_REQ)) dut (
        .CLK (CLK),
        .R   (R),
        .bus (arb_bus.master)
    );

    always #5 CLK = ~CLK;

    // Serializer model: busy one cycle after TX_RQ, for nine cycles; unaffected by R.
    always @(posedge CLK) begin
        if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
        else if (arb_bus.TX_RQ) busy_cnt <= 9;
    end
    assign arb_bus.TX_BUSY = force_busy | (busy_cnt != 0);

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] req, input logic [3:0] lock, input logic [31:0] data);
        arb_bus.REQ  = req;
        arb_bus.LOCK = lock;
        arb_bus.DATA = data;
    endtask

    task automatic pushExp(input int idx, input logic [7:0] data);
        exp_t e;
        e.idx  = idx;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Scoreboard: every ACK pulse must match the oldest expected grant.
    always @(negedge CLK) begin
        exp_t e;
        if (arb_bus.ACK != '0) begin
            if (exp_q.size() == 0) begin
                checkOutput("sb_unexpected_ack", 32'(arb_bus.ACK), 32'h0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("sb_ack", 32'(arb_bus.ACK), 32'(1) << e.idx);
                checkOutput("sb_txdata", 32'(arb_bus.TXDATA), 32'(e.data));
                checkOutput("sb_owner", 32'(arb_bus.OWNER), 32'(e.idx));
                checkOutput("sb_txrq", 32'(arb_bus.TX_RQ), 32'h1);
                checkOutput("sb_active", 32'(arb_bus.ACTIVE), 32'h1);
            end
            checkOutput("sb_ack_one_cycle", 32'(prev_ack), 32'h0);
        end
        prev_ack = arb_bus.ACK;
    end

    task automatic waitAck(input int idx, input string tag);
        logic got;
        got      = 1'b0;
        saw_idle = 1'b0;
        for (int n = 0; n < 80 && !got; n++) begin
            @(negedge CLK);
            if (arb_bus.ACK[idx[1:0]]) got = 1'b1;
            else if (!arb_bus.ACTIVE) saw_idle = 1'b1;
        end
        if (!got) checkOutput({tag, "_ack_timeout"}, 32'h0, 32'h1);
    endtask

    task automatic waitIdle(input string tag);
        logic done;
        done = 1'b0;
        for (int n = 0; n < 80 && !done; n++) begin
            @(negedge CLK);
            if (!arb_bus.ACTIVE && !arb_bus.TX_BUSY && !arb_bus.TX_RQ) done = 1'b1;
        end
        if (!done) checkOutput({tag, "_idle_timeout"}, 32'h0, 32'h1);
    endtask

    task automatic doReset();
        R = 1'b1;
        repeat (2) @(negedge CLK);
        R = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int rq_cnt;
        int bad;
        int acks;
        logic fell;
        logic busy_seen;

        applyStimulus(4'b0000, 4'b0000, 32'h0);
        @(negedge CLK);
        checkOutput("reset_outputs", 32'({arb_bus.ACK, arb_bus.TXDATA, arb_bus.TX_RQ, arb_bus.OWNER, arb_bus.ACTIVE}), 32'h0);
        R = 1'b0;
        @(negedge CLK);
        checkOutput("idle_no_req", 32'({arb_bus.ACK, arb_bus.TX_RQ, arb_bus.ACTIVE}), 32'h0);

        $display("[TB] single byte");
        data_v = 32'h0;
        data_v[2*SIZE +: SIZE] = 8'hA5;
        pushExp(2, 8'hA5);
        applyStimulus(4'b0100, 4'b0000, data_v);
        waitAck(2, "t1");
        arb_bus.REQ = 4'b0000;
        rq_cnt    = 1;
        fell      = 1'b0;
        busy_seen = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(negedge CLK);
            if (arb_bus.TX_RQ) rq_cnt++;
            if (fell) begin
                checkOutput("t1_active_drop", 32'(arb_bus.ACTIVE), 32'h0);
                break;
            end
            if (busy_seen && !arb_bus.TX_BUSY) begin
                checkOutput("t1_active_hold", 32'(arb_bus.ACTIVE), 32'h1);
                fell = 1'b1;
            end
            if (arb_bus.TX_BUSY) busy_seen = 1'b1;
        end
        checkOutput("t1_frame_end_seen", 32'(fell), 32'h1);
        checkOutput("t1_txrq_cycles", 32'(rq_cnt), 32'd2);
        checkOutput("t1_txdata_hold", 32'(arb_bus.TXDATA), 32'hA5);
        checkOutput("t1_owner_hold", 32'(arb_bus.OWNER), 32'd2);

        $display("[TB] round-robin fairness");
        doReset();
        data_v = 32'h13121110;
`ifdef UART_TX_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 5; i++) pushExp(0, 8'h10);
`else
        pushExp(0, 8'h10); pushExp(1, 8'h11); pushExp(2, 8'h12); pushExp(3, 8'h13); pushExp(0, 8'h10);
`endif
        applyStimulus(4'b1111, 4'b0000, data_v);
        acks = 0;
        for (int n = 0; n < 400 && acks < 5; n++) begin
            @(negedge CLK);
            if (arb_bus.ACK != '0) acks++;
        end
        checkOutput("t2_grant_count", 32'(acks), 32'd5);
        arb_bus.REQ = 4'b0000;
        waitIdle("t2");

        $display("[TB] lock burst");
        data_v = 32'hC3000000;
        data_v[1*SIZE +: SIZE] = 8'hB0;
        pushExp(1, 8'hB0); pushExp(1, 8'hB1); pushExp(1, 8'hB2); pushExp(3, 8'hC3);
        applyStimulus(4'b1010, 4'b0010, data_v);
        waitAck(1, "t3_b0");
        arb_bus.DATA[1*SIZE +: SIZE] = 8'hB1;
        waitAck(1, "t3_b1");
        checkOutput("t3_no_gap_b1", 32'(saw_idle), 32'h0);
        arb_bus.DATA[1*SIZE +: SIZE] = 8'hB2;
        waitAck(1, "t3_b2");
        checkOutput("t3_no_gap_b2", 32'(saw_idle), 32'h0);
        applyStimulus(4'b1000, 4'b0000, arb_bus.DATA);
        waitAck(3, "t3_r3");
        checkOutput("t3_gap_before_r3", 32'(saw_idle), 32'h1);
        arb_bus.REQ = 4'b0000;
        waitIdle("t3");

        $display("[TB] busy gating");
        force_busy = 1'b1;
        applyStimulus(4'b0001, 4'b0000, 32'h0000005A);
        bad = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge CLK);
            if (arb_bus.ACK != '0 || arb_bus.TX_RQ || arb_bus.ACTIVE) bad++;
        end
        checkOutput("t4_no_grant_while_busy", 32'(bad), 32'h0);
        pushExp(0, 8'h5A);
        force_busy = 1'b0;
        @(negedge CLK);
        checkOutput("t4_grant_next_edge", 32'(arb_bus.ACK), 32'h1);
        arb_bus.REQ = 4'b0000;
        waitIdle("t4");

        $display("[TB] reset mid-frame");
        pushExp(2, 8'h77);
        applyStimulus(4'b0100, 4'b0000, 32'h00770000);
        waitAck(2, "t5_pre");
        arb_bus.REQ = 4'b0000;
        repeat (2) @(negedge CLK);
        checkOutput("t5_in_send", 32'({arb_bus.TX_RQ, arb_bus.TX_BUSY, arb_bus.ACTIVE}), 32'b011);
        force_busy = 1'b1;
        R = 1'b1;
        #1;
        checkOutput("t5_async_clear", 32'({arb_bus.ACK, arb_bus.TXDATA, arb_bus.TX_RQ, arb_bus.OWNER, arb_bus.ACTIVE}), 32'h0);
        checkOutput("t5_async_owner", 32'(arb_bus.OWNER), 32'h0);
        @(negedge CLK);
        R = 1'b0;
        applyStimulus(4'b0101, 4'b0000, 32'h00E200E0);
        bad = 0;
        for (int n = 0; n < 20 && (n < 5 || busy_cnt != 0); n++) begin
            @(negedge CLK);
            if (arb_bus.ACK != '0 || arb_bus.TX_RQ || arb_bus.ACTIVE) bad++;
        end
        checkOutput("t5_no_grant_while_busy", 32'(bad), 32'h0);
        pushExp(0, 8'hE0); pushExp(2, 8'hE2);
        force_busy = 1'b0;
        waitAck(0, "t5_r0");
        arb_bus.REQ = 4'b0100;
        waitAck(2, "t5_r2");
        arb_bus.REQ = 4'b0000;
        waitIdle("t5");

        $display("[TB] late request");
        pushExp(0, 8'h31);
        applyStimulus(4'b0001, 4'b0000, 32'h00420031);
        waitAck(0, "t6_r0");
        arb_bus.REQ = 4'b0000;
        @(negedge CLK);
        arb_bus.REQ = 4'b0100;
        repeat (3) @(negedge CLK);
        arb_bus.DATA[2*SIZE +: SIZE] = 8'h99;
        pushExp(2, 8'h99);
        waitAck(2, "t6_r2");
        checkOutput("t6_idle_before_grant", 32'(saw_idle), 32'h1);
        arb_bus.REQ = 4'b0000;
        waitIdle("t6");

        checkOutput("sb_all_consumed", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
